instr_sequencer: RTL and testbench

//  Upstream control stage for data_path. Buffers 16-bit register-register instructions,

---
 rtl/instr_sequencer_pkg.sv | 26 ++
 rtl/instr_sequencer_if.sv | 29 ++
 rtl/instr_sequencer_fifo.sv | 71 +++++++
 rtl/instr_sequencer.sv | 106 ++++++++++
 tb/tb_instr_sequencer.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer.
//  - INSTR_W : width of a raw instruction word
//  - entry_t : one FIFO entry / instruction register, {last, instr[15:3]}
//  - state_e : sequencer FSM states
package instr_sequencer_pkg;

  localparam int INSTR_W = 16;

  typedef struct packed {
    logic       last;
    logic [3:0] opcode;
    logic [2:0] dest;
    logic [2:0] src1;
    logic [2:0] src2;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WRITE = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/instr_sequencer_if.sv
// Bus between the instruction source and the sequencer, plus the decoded
// outputs to data_path.
//  master : instruction source (drives in_valid/in_instr/in_last)
//  slave  : sequencer (drives in_ready, decoded fields, WR, DONE, busy)
interface instr_sequencer_if;
  import instr_sequencer_pkg::*;

  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic               in_last;
  logic               in_ready;
  logic [3:0]         opcode;
  logic [2:0]         src1;
  logic [2:0]         src2;
  logic [2:0]         dest;
  logic               WR;
  logic               DONE;
  logic               busy;

  modport master (
    output in_valid, in_instr, in_last,
    input  in_ready, opcode, src1, src2, dest, WR, DONE, busy
  );

  modport slave (
    input  in_valid, in_instr, in_last,
    output in_ready, opcode, src1, src2, dest, WR, DONE, busy
  );
endinterface

// File: rtl/instr_sequencer_fifo.sv
// Synchronous FIFO holding buffered instructions.
//  clk, rst     : clock, synchronous active-high reset (pointers/count only)
//  push_i       : write request, ignored while full (even if popping)
//  push_data_i  : entry to write
//  pop_i        : read request, ignored while empty
//  pop_data_o   : entry at the head (valid when !empty_o)
//  full_o/empty_o/count_o : occupancy, all from registered count
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 14,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [W-1:0]     push_data_i,
  input  logic             pop_i,
  output logic [W-1:0]     pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Full refuses a push regardless of a same-cycle pop.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: buffers instructions, decodes them into
// opcode/src1/src2/dest for data_path, holds the fields for EXEC_CYCLES
// while the ALU settles, then pulses WR once. DONE pulses the cycle after
// the write of an instruction tagged last.
//  clk, rst : clock, synchronous active-high reset
//  bus      : instr_sequencer_if.slave (input handshake + decoded outputs)
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  instr_sequencer_if.slave   bus
);

  localparam int CNT_W  = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam int FCNT_W = $clog2(DEPTH) + 1;

  state_e             state_q;
  entry_t             ir_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               wr_q;
  logic               done_q;

  entry_t             push_entry;
  logic [ENTRY_W-1:0] fifo_rd_data;
  logic               fifo_full, fifo_empty, fifo_pop;
  logic [FCNT_W-1:0]  fifo_count;
  logic               unused_instr_bits;

  // Low three instruction bits carry no information.
  assign unused_instr_bits = &bus.in_instr[2:0];
  assign push_entry = {bus.in_last, bus.in_instr[INSTR_W-1:3]};

  // Pop only from IDLE; the FSM takes the head entry on the same edge.
  assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

  instr_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (bus.in_valid),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_rd_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // WR/DONE are registered: they are set on the edge entering WRITE/FIN,
  // so each is high for exactly the cycle the FSM spends in that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            ir_q    <= entry_t'(fifo_rd_data);
            cnt_q   <= CNT_W'(EXEC_CYCLES - 1);
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_q == '0) begin
            state_q <= ST_WRITE;
            wr_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_WRITE: begin
          if (ir_q.last) begin
            state_q <= ST_FIN;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready = !fifo_full;
  assign bus.opcode   = ir_q.opcode;
  assign bus.dest     = ir_q.dest;
  assign bus.src1     = ir_q.src1;
  assign bus.src2     = ir_q.src2;
  assign bus.WR       = wr_q;
  assign bus.DONE     = done_q;
  assign bus.busy     = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  logic clk = 1'b0;
  logic rst1, rst3;
  int   vectors = 0;
  int   miscompares = 0;

  logic [12:0] sbq [$];

  always #5 clk = ~clk;

  instr_sequencer_if if1 ();
  instr_sequencer_if if3 ();

  instr_sequencer #(.DEPTH(4), .EXEC_CYCLES(1)) dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));
  instr_sequencer #(.DEPTH(4), .EXEC_CYCLES(3)) dut3 (.clk(clk), .rst(rst3), .bus(if3.slave));

  task automatic test_reset();
    rst1 = 1'b1; rst3 = 1'b1;
    if1.in_valid = 1'b1; if1.in_instr = 16'h5298; if1.in_last = 1'b1;
    if3.in_valid = 1'b1; if3.in_instr = 16'h5298; if3.in_last = 1'b1;
    repeat (3) @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0;
    if1.in_valid = 1'b0; if3.in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (if1.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready1: got %b expected 1", if1.in_ready); end
    vectors++; if (if1.WR !== 1'b0) begin miscompares++; $display("FAIL reset_wr1: got %b expected 0", if1.WR); end
    vectors++; if (if1.DONE !== 1'b0) begin miscompares++; $display("FAIL reset_done1: got %b expected 0", if1.DONE); end
    vectors++; if (if1.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy1: got %b expected 0", if1.busy); end
    vectors++; if ({if1.opcode, if1.dest, if1.src1, if1.src2} !== 13'h0) begin miscompares++; $display("FAIL reset_fields1: got %h expected 0", {if1.opcode, if1.dest, if1.src1, if1.src2}); end
    vectors++; if (if3.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready3: got %b expected 1", if3.in_ready); end
    vectors++; if (if3.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy3: got %b expected 0", if3.busy); end
    repeat (3) begin
      @(negedge clk);
      vectors++; if (if1.busy !== 1'b0 || if1.WR !== 1'b0) begin miscompares++; $display("FAIL reset_no_push: busy=%b WR=%b expected 0 0", if1.busy, if1.WR); end
    end
  endtask

  task automatic test_single();
    if1.in_valid = 1'b1; if1.in_instr = 16'h5298; if1.in_last = 1'b1;
    vectors++; if (if1.in_ready !== 1'b1) begin miscompares++; $display("FAIL single_accept: in_ready=%b expected 1", if1.in_ready); end
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if1.in_valid = 1'b0; if1.in_last = 1'b0;
      vectors++; if (if1.WR !== (cyc == 3)) begin miscompares++; $display("FAIL single_wr c%0d: got %b expected %b", cyc, if1.WR, (cyc == 3)); end
      vectors++; if (if1.DONE !== (cyc == 4)) begin miscompares++; $display("FAIL single_done c%0d: got %b expected %b", cyc, if1.DONE, (cyc == 4)); end
      vectors++; if (if1.busy !== (cyc <= 4)) begin miscompares++; $display("FAIL single_busy c%0d: got %b expected %b", cyc, if1.busy, (cyc <= 4)); end
      if (cyc >= 3) begin
        vectors++;
        if ({if1.opcode, if1.dest, if1.src1, if1.src2} !== {4'd5, 3'd1, 3'd2, 3'd3}) begin
          miscompares++;
          $display("FAIL single_fields c%0d: got op%0d d%0d s%0d s%0d expected op5 d1 s2 s3", cyc, if1.opcode, if1.dest, if1.src1, if1.src2);
        end
      end
    end
  endtask

  // Stream of n back-to-back offers; every accepted instruction is queued
  // and popped/compared when WR appears.
  task automatic test_back_to_back(input int n, input string tag);
    logic [15:0] instrs [8];
    int idx = 0, wrs = 0, dones = 0, last_wr = -1, refused = 0;
    bit saw_full = 0;
    logic [12:0] e;
    for (int i = 0; i < n; i++) instrs[i] = 16'($urandom);
    sbq.delete();
    for (int cyc = 0; cyc < n * 3 + 10; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (if1.WR) begin
        wrs++;
        vectors++;
        if (sbq.size() == 0) begin
          miscompares++; $display("FAIL %s_wr_extra c%0d: WR with empty scoreboard", tag, cyc);
        end else begin
          e = sbq.pop_front();
          if ({if1.opcode, if1.dest, if1.src1, if1.src2} !== e) begin
            miscompares++; $display("FAIL %s_order c%0d: got %h expected %h", tag, cyc, {if1.opcode, if1.dest, if1.src1, if1.src2}, e);
          end
        end
        if (last_wr >= 0) begin
          vectors++;
          if (cyc - last_wr != 3) begin miscompares++; $display("FAIL %s_spacing: got %0d expected 3", tag, cyc - last_wr); end
        end
        last_wr = cyc;
      end
      if (if1.DONE) begin
        dones++;
        vectors++;
        if (cyc != last_wr + 1 || wrs != n) begin miscompares++; $display("FAIL %s_done_pos c%0d: last WR c%0d wrs %0d expected %0d", tag, cyc, last_wr, wrs, n); end
      end
      if (!if1.in_ready) saw_full = 1;
      if (idx < n) begin
        if1.in_valid = 1'b1; if1.in_instr = instrs[idx]; if1.in_last = (idx == n - 1);
        if (if1.in_ready) begin
          sbq.push_back(instrs[idx][15:3]);
          idx++;
        end else begin
          refused++;
        end
      end else begin
        if1.in_valid = 1'b0; if1.in_last = 1'b0;
      end
    end
    vectors++; if (wrs != n) begin miscompares++; $display("FAIL %s_wr_count: got %0d expected %0d", tag, wrs, n); end
    vectors++; if (dones != 1) begin miscompares++; $display("FAIL %s_done_count: got %0d expected 1", tag, dones); end
    vectors++; if (sbq.size() != 0) begin miscompares++; $display("FAIL %s_leftover: got %0d expected 0", tag, sbq.size()); end
    vectors++; if (!saw_full) begin miscompares++; $display("FAIL %s_full_seen: got 0 expected 1", tag); end
    if (n > 6) begin
      vectors++; if (refused == 0) begin miscompares++; $display("FAIL %s_refused: got 0 expected >0", tag); end
    end
  endtask

  task automatic test_exec3();
    if3.in_valid = 1'b1; if3.in_instr = 16'hAB88; if3.in_last = 1'b0;
    vectors++; if (if3.in_ready !== 1'b1) begin miscompares++; $display("FAIL exec3_accept: in_ready=%b expected 1", if3.in_ready); end
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      if3.in_valid = 1'b0;
      vectors++; if (if3.WR !== (cyc == 5)) begin miscompares++; $display("FAIL exec3_wr c%0d: got %b expected %b", cyc, if3.WR, (cyc == 5)); end
      vectors++; if (if3.DONE !== 1'b0) begin miscompares++; $display("FAIL exec3_done c%0d: got %b expected 0", cyc, if3.DONE); end
      if (cyc >= 2) begin
        vectors++;
        if ({if3.opcode, if3.dest, if3.src1, if3.src2} !== {4'hA, 3'd5, 3'd6, 3'd1}) begin
          miscompares++; $display("FAIL exec3_fields c%0d: got %h expected %h", cyc, {if3.opcode, if3.dest, if3.src1, if3.src2}, {4'hA, 3'd5, 3'd6, 3'd1});
        end
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    if3.in_valid = 1'b1; if3.in_instr = 16'h1234; if3.in_last = 1'b1;
    @(negedge clk);
    if3.in_instr = 16'h7E50;
    @(negedge clk);
    if3.in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (if3.busy !== 1'b1 || if3.WR !== 1'b0) begin miscompares++; $display("FAIL midrst_pre: busy=%b WR=%b expected 1 0", if3.busy, if3.WR); end
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    vectors++; if ({if3.opcode, if3.dest, if3.src1, if3.src2} !== 13'h0) begin miscompares++; $display("FAIL midrst_fields: got %h expected 0", {if3.opcode, if3.dest, if3.src1, if3.src2}); end
    vectors++; if (if3.busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", if3.busy); end
    vectors++; if (if3.in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready: got %b expected 1", if3.in_ready); end
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      vectors++; if (if3.WR !== 1'b0 || if3.DONE !== 1'b0 || if3.busy !== 1'b0) begin miscompares++; $display("FAIL midrst_quiet c%0d: WR=%b DONE=%b busy=%b expected 0 0 0", cyc, if3.WR, if3.DONE, if3.busy); end
    end
  endtask

  initial begin
    rst1 = 1'b1; rst3 = 1'b1;
    if1.in_valid = 1'b0; if1.in_instr = '0; if1.in_last = 1'b0;
    if3.in_valid = 1'b0; if3.in_instr = '0; if3.in_last = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    repeat (2) @(negedge clk);
    test_back_to_back(6, "burst");
    repeat (2) @(negedge clk);
    test_exec3();
    repeat (2) @(negedge clk);
    test_reset_mid_exec();
    repeat (2) @(negedge clk);
    test_back_to_back(8, "fullpop");
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
